// File: rtl/countdown_timer_if.sv
// Control/status bundle between a timer client and countdown_timer.
// master drives load/start/pause/reload requests and observes enable, complete and count.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             start;
    logic             pause;
    logic             reload_en;
    logic             enable;
    logic             complete;
    logic [WIDTH-1:0] count;

    modport master (
        output load, load_value, start, pause, reload_en,
        input  enable, complete, count
    );

    modport slave (
        input  load, load_value, start, pause, reload_en,
        output enable, complete, count
    );
endinterface

// File: rtl/countdown_timer.sv
// Prescaled down-counter with pause/resume, auto-reload and a one-cycle expiry pulse.
// Latency: N*PRESCALE cycles from RUN entry to EXPIRED; no backpressure, requests are sampled every cycle.
module countdown_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4
) (
    input  logic           clk,
    input  logic           reset,
    countdown_timer_if.slave tif
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [7:0]       PS_LAST = 8'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [7:0]       presc_q, presc_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        case (state_q)
            IDLE: begin
                if (tif.load) begin
                    count_d  = tif.load_value;
                    reload_d = tif.load_value;
                    presc_d  = '0;
                end else if (tif.start && count_q != '0) begin
                    state_d = RUN;
                    presc_d = '0;
                end
            end
            RUN: begin
                // pause wins over a decrement due on the same edge
                if (tif.pause) begin
                    state_d = HOLD;
                end else if (presc_q == PS_LAST) begin
                    presc_d = '0;
                    if (count_q != '0) begin
                        count_d = count_q - ONE;
                    end
                    if (count_q == ONE) begin
                        state_d = EXPIRED;
                    end
                end else begin
                    presc_d = presc_q + 8'd1;
                end
            end
            HOLD: begin
                if (tif.start) begin
                    state_d = RUN;
                end else if (tif.load) begin
                    count_d  = tif.load_value;
                    reload_d = tif.load_value;
                    presc_d  = '0;
                    state_d  = IDLE;
                end
            end
            EXPIRED: begin
                if (tif.reload_en && reload_q != '0) begin
                    count_d = reload_q;
                    presc_d = '0;
                    state_d = RUN;
                end else begin
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tif.enable   = (state_q == RUN);
    assign tif.complete = (state_q == EXPIRED);
    assign tif.count    = count_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: vector table, directed multi-cycle sequences, then random traffic
// against a remaining-ticks reference model.
module tb_countdown_timer;
    localparam int P = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    countdown_timer_if #(.WIDTH(8)) tif ();
    countdown_timer #(.WIDTH(8), .PRESCALE(P)) dut (.clk(clk), .reset(reset), .tif(tif));

    int checks = 0;
    int errors = 0;

    // Reference model: mode plus total RUN ticks left before expiry (count*P - prescaler).
    int m_mode = 0;   // 0 idle, 1 run, 2 hold, 3 expired
    int m_rem  = 0;
    int m_rld  = 0;

    typedef struct {
        logic       rst, ld;
        logic [7:0] lv;
        logic       st, pa, rl;
        logic       en, cmp;
        int         cnt;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic ld, input logic [7:0] lv,
                                input logic st, input logic pa, input logic rl,
                                input logic en, input logic cmp, input int cnt);
        vec_t v;
        v.rst = rst; v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.rl = rl;
        v.en = en; v.cmp = cmp; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic ld, input logic [7:0] lv,
                              input logic st, input logic pa, input logic rl);
        if (rst) begin
            m_mode = 0; m_rem = 0; m_rld = 0;
        end else begin
            case (m_mode)
                0: if (ld) begin
                       m_rem = int'(lv) * P; m_rld = int'(lv);
                   end else if (st && m_rem != 0) begin
                       m_rem = ((m_rem + P - 1) / P) * P;
                       m_mode = 1;
                   end
                1: if (pa) m_mode = 2;
                   else begin
                       m_rem = m_rem - 1;
                       if (m_rem == 0) m_mode = 3;
                   end
                2: if (st) m_mode = 1;
                   else if (ld) begin
                       m_rem = int'(lv) * P; m_rld = int'(lv); m_mode = 0;
                   end
                default: if (rl && m_rld != 0) begin
                             m_rem = m_rld * P; m_mode = 1;
                         end else begin
                             m_rem = 0; m_mode = 0;
                         end
            endcase
        end
    endtask

    // One clock: drive inputs, advance the model, sample 1ns after the edge and compare.
    task automatic cycle(input logic rst, input logic ld, input logic [7:0] lv,
                         input logic st, input logic pa, input logic rl);
        reset = rst; tif.load = ld; tif.load_value = lv;
        tif.start = st; tif.pause = pa; tif.reload_en = rl;
        @(posedge clk);
        model_step(rst, ld, lv, st, pa, rl);
        #1;
        check("model_enable", int'(tif.enable), int'(m_mode == 1));
        check("model_complete", int'(tif.complete), int'(m_mode == 3));
        check("model_count", int'(tif.count), (m_rem + P - 1) / P);
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    vec_t tbl[12];

    initial begin
        int en_cnt, hit, pulses, bad, last;

        tbl[0]  = mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 0);  // reset
        tbl[1]  = mk(0, 0, 8'd0, 1, 0, 0, 0, 0, 0);  // start with count 0
        tbl[2]  = mk(0, 1, 8'd2, 1, 0, 0, 0, 0, 2);  // load beats start
        tbl[3]  = mk(0, 0, 8'd0, 0, 1, 0, 0, 0, 2);  // pause in idle
        tbl[4]  = mk(0, 0, 8'd0, 1, 0, 0, 1, 0, 2);  // enter run
        tbl[5]  = mk(0, 0, 8'd0, 0, 0, 0, 1, 0, 2);
        tbl[6]  = mk(0, 1, 8'd9, 1, 0, 0, 1, 0, 2);  // load ignored in run
        tbl[7]  = mk(0, 0, 8'd0, 0, 0, 0, 1, 0, 2);
        tbl[8]  = mk(0, 0, 8'd0, 0, 0, 0, 1, 0, 1);  // first decrement
        tbl[9]  = mk(0, 0, 8'd0, 0, 1, 0, 0, 0, 1);  // hold
        tbl[10] = mk(0, 1, 8'd6, 0, 1, 0, 0, 0, 6);  // load from hold -> idle
        tbl[11] = mk(1, 0, 8'd0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rst, tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].pa, tbl[i].rl);
            check($sformatf("tbl%0d_enable", i), int'(tif.enable), int'(tbl[i].en));
            check($sformatf("tbl%0d_complete", i), int'(tif.complete), int'(tbl[i].cmp));
            check($sformatf("tbl%0d_count", i), int'(tif.count), tbl[i].cnt);
        end

        // Load 3, start: 12 enable cycles, then one complete, then idle.
        cycle(1, 0, 8'd0, 0, 0, 0);
        cycle(0, 1, 8'd3, 0, 0, 0);
        cycle(0, 0, 8'd0, 1, 0, 0);
        en_cnt = int'(tif.enable); hit = -1;
        for (int k = 1; k <= 20; k++) begin
            idle_cycle();
            if (k == 4) check("seq034_count_at4", int'(tif.count), 2);
            if (k == 8) check("seq034_count_at8", int'(tif.count), 1);
            if (tif.complete) begin hit = k; break; end
            if (tif.enable) en_cnt++;
        end
        check("seq034_enable_cycles", en_cnt, 12);
        check("seq034_complete_at", hit, 12);
        idle_cycle();
        check("seq034_complete_one_cycle", int'(tif.complete), 0);
        check("seq034_final_count", int'(tif.count), 0);

        // Load 5, 6 run cycles, hold 10 cycles, resume: expiry 14 cycles later.
        cycle(0, 1, 8'd5, 0, 0, 0);
        cycle(0, 0, 8'd0, 1, 0, 0);
        for (int k = 0; k < 6; k++) idle_cycle();
        for (int k = 0; k < 10; k++) cycle(0, 0, 8'd0, 0, 1, 0);
        check("seq035_hold_count", int'(tif.count), 4);
        check("seq035_hold_enable", int'(tif.enable), 0);
        cycle(0, 0, 8'd0, 1, 0, 0);
        hit = -1;
        for (int k = 1; k <= 30; k++) begin
            idle_cycle();
            if (tif.complete) begin hit = k; break; end
        end
        check("seq035_complete_after_resume", hit, 14);

        // Auto-reload with 2: complete every 9 cycles, enable low only while expired.
        cycle(1, 0, 8'd0, 0, 0, 0);
        cycle(0, 1, 8'd2, 0, 0, 1);
        cycle(0, 0, 8'd0, 1, 0, 1);
        pulses = 0; bad = 0; last = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle(0, 0, 8'd0, 0, 0, 1);
            if (tif.enable == tif.complete) bad++;
            if (tif.complete) begin
                if (k - last != (pulses == 0 ? 8 : 9)) bad++;
                last = k; pulses++;
            end
        end
        check("seq036_pulses", pulses, 3);
        check("seq036_spacing_and_enable", bad, 0);

        // Reset mid-run at count 7, then start without load stays idle.
        cycle(0, 0, 8'd0, 0, 1, 0);
        cycle(1, 0, 8'd0, 0, 0, 0);
        cycle(0, 1, 8'd8, 0, 0, 0);
        cycle(0, 0, 8'd0, 1, 0, 0);
        for (int k = 0; k < 4; k++) idle_cycle();
        check("seq038_count7", int'(tif.count), 7);
        cycle(1, 0, 8'd0, 1, 0, 0);
        check("seq038_reset_count", int'(tif.count), 0);
        check("seq038_reset_enable", int'(tif.enable), 0);
        check("seq038_reset_complete", int'(tif.complete), 0);
        cycle(0, 0, 8'd0, 1, 0, 0);
        check("seq038_start_no_load", int'(tif.enable), 0);

        // Pause on the decrement edge, then start+pause resumes with prescaler kept.
        cycle(0, 1, 8'd2, 0, 0, 0);
        cycle(0, 0, 8'd0, 1, 0, 0);
        for (int k = 0; k < 3; k++) idle_cycle();
        cycle(0, 0, 8'd0, 0, 1, 0);
        check("seq039_hold_count", int'(tif.count), 2);
        check("seq039_hold_enable", int'(tif.enable), 0);
        cycle(0, 0, 8'd0, 1, 1, 0);
        check("seq039_resume_enable", int'(tif.enable), 1);
        idle_cycle();
        check("seq039_prescaler_kept", int'(tif.count), 1);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom_range(63) == 0),
                  ($urandom_range(7) == 0),
                  8'($urandom_range(6)),
                  ($urandom_range(3) == 0),
                  ($urandom_range(5) == 0),
                  ($urandom_range(1) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
